alu_serial_wrapper: RTL



---
 rtl/alu_serial_wrapper.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/alu_serial_wrapper.sv
// Byte-serial ALU/multiplier wrapper with DW-bit operands.
// Operands load LSB first, the result streams out LSB first, then a flag byte.
module alu_serial_wrapper #(
    parameter int DW = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_i,
    input  logic       load_a_i,
    input  logic       load_b_i,
    input  logic       load_cmd_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       done_o,
    output logic       busy_o
);

    localparam int NB = DW / 8;
    localparam int CW = $clog2(2 * NB + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;
    localparam logic [1:0] S_FLAG = 2'd3;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;

    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [1:0]      state_q, state_d;
    logic [DW-1:0]   ra_q, ra_d;
    logic [DW-1:0]   rb_q, rb_d;
    logic            mul_q, mul_d;
    logic            ci_q, ci_d;
    logic [2:0]      op_q, op_d;
    logic [2*DW-1:0] r_q, r_d;
    logic [7:0]      f_q, f_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [DW-1:0]   bop;
    logic [DW:0]     sum;
    logic [DW-1:0]   res;
    logic [2*DW-1:0] prod;
    logic            c_f, v_f, z_f, n_f;

    // Datapath: SUB reuses the adder with inverted B
    always_comb begin
        bop  = (op_q == OP_SUB) ? ~rb_q : rb_q;
        sum  = {1'b0, ra_q} + {1'b0, bop} + {{DW{1'b0}}, ci_q};
        prod = {{DW{1'b0}}, ra_q} * {{DW{1'b0}}, rb_q};
        res  = '0;
        c_f  = 1'b0;
        v_f  = 1'b0;
        case (op_q)
            OP_ADD, OP_SUB: begin
                res = sum[DW-1:0];
                c_f = sum[DW];
                v_f = (ra_q[DW-1] == bop[DW-1]) &&
                      (sum[DW-1] != ra_q[DW-1]);
            end
            OP_AND: res = ra_q & rb_q;
            OP_OR:  res = ra_q | rb_q;
            OP_XOR: res = ra_q ^ rb_q;
            OP_SHL: begin
                res = {ra_q[DW-2:0], ci_q};
                c_f = ra_q[DW-1];
            end
            OP_SHR: begin
                res = {ci_q, ra_q[DW-1:1]};
                c_f = ra_q[0];
            end
            default: res = rb_q;
        endcase
        if (mul_q) begin
            c_f = 1'b0;
            v_f = 1'b0;
            z_f = (prod == '0);
            n_f = prod[2*DW-1];
        end else begin
            z_f = (res == '0);
            n_f = res[DW-1];
        end
    end

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        mul_d   = mul_q;
        ci_d    = ci_q;
        op_d    = op_q;
        r_d     = r_q;
        f_d     = f_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (load_cmd_i) begin
                    mul_d   = data_i[7];
                    ci_d    = data_i[3];
                    op_d    = data_i[2:0];
                    state_d = S_EXEC;
                end else if (load_b_i) begin
                    rb_d = {data_i, rb_q[DW-1:8]};
                end else if (load_a_i) begin
                    ra_d = {data_i, ra_q[DW-1:8]};
                end
            end
            S_EXEC: begin
                r_d     = mul_q ? prod : {{DW{1'b0}}, res};
                f_d     = {4'b0, c_f, v_f, z_f, n_f};
                cnt_d   = mul_q ? CW'(2 * NB) : CW'(NB);
                state_d = S_OUT;
            end
            S_OUT: begin
                r_d   = r_q >> 8;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = S_FLAG;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            mul_q   <= 1'b0;
            ci_q    <= 1'b0;
            op_q    <= '0;
            r_q     <= '0;
            f_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            mul_q   <= mul_d;
            ci_q    <= ci_d;
            op_q    <= op_d;
            r_q     <= r_d;
            f_q     <= f_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        data_o  = 8'h00;
        valid_o = 1'b0;
        done_o  = 1'b0;
        if (state_q == S_OUT) begin
            data_o  = r_q[7:0];
            valid_o = 1'b1;
        end else if (state_q == S_FLAG) begin
            data_o  = f_q;
            valid_o = 1'b1;
            done_o  = 1'b1;
        end
    end

    assign busy_o = (state_q != S_IDLE);

endmodule
